// File: rtl/vpu_lane_seq_ctrl_if.sv
// Handshake and data bundle between the VPU lane sequencer and its neighbours:
// request decoder, operand buffer, lane instance, result stream and completion.
interface vpu_lane_seq_ctrl_if #(
  parameter int OPERAND_WIDTH = 32,
  parameter int SRC_CNT       = 3,
  parameter int OPCODE_W      = 4,
  parameter int BEAT_W        = 8
);
  logic                             req_valid_i;
  logic                             req_ready_o;
  logic [OPCODE_W-1:0]              req_opcode_i;
  logic [BEAT_W-1:0]                req_beats_i;
  logic                             src_valid_i;
  logic                             src_ready_o;
  logic [SRC_CNT*OPERAND_WIDTH-1:0] src_data_i;
  logic                             lane_start_o;
  logic [OPCODE_W-1:0]              lane_opcode_o;
  logic [SRC_CNT*OPERAND_WIDTH-1:0] lane_operand_o;
  logic                             lane_done_i;
  logic [OPERAND_WIDTH-1:0]         lane_dout_i;
  logic                             res_valid_o;
  logic                             res_ready_i;
  logic [OPERAND_WIDTH-1:0]         res_data_o;
  logic                             res_last_o;
  logic                             cmpl_valid_o;
  logic                             cmpl_err_o;
  logic                             busy_o;

  // Sequencer side
  modport slave (
    input  req_valid_i, req_opcode_i, req_beats_i,
    input  src_valid_i, src_data_i,
    input  lane_done_i, lane_dout_i,
    input  res_ready_i,
    output req_ready_o, src_ready_o,
    output lane_start_o, lane_opcode_o, lane_operand_o,
    output res_valid_o, res_data_o, res_last_o,
    output cmpl_valid_o, cmpl_err_o, busy_o
  );

  // Environment side (decoder, operand buffer, lane, result consumer)
  modport master (
    output req_valid_i, req_opcode_i, req_beats_i,
    output src_valid_i, src_data_i,
    output lane_done_i, lane_dout_i,
    output res_ready_i,
    input  req_ready_o, src_ready_o,
    input  lane_start_o, lane_opcode_o, lane_operand_o,
    input  res_valid_o, res_data_o, res_last_o,
    input  cmpl_valid_o, cmpl_err_o, busy_o
  );
endinterface

// File: rtl/vpu_lane_seq_ctrl.sv
// Sequences one VPU lane through a multi-beat vector op: per beat it fetches an
// operand set, pulses lane start, waits (with timeout) for lane done and offers
// the result on a backpressured stream; finishes with a completion pulse.
module vpu_lane_seq_ctrl #(
  parameter int                       OPERAND_WIDTH = 32,
  parameter int                       SRC_CNT       = 3,
  parameter int                       OPCODE_W      = 4,
  parameter int                       BEAT_W        = 8,
  parameter int                       TIMEOUT       = 255,
  parameter logic [2**OPCODE_W-1:0]   LEGAL_OPC     = 16'h0FFF
) (
  input logic                clk,
  input logic                rst,
  vpu_lane_seq_ctrl_if.slave bus
);

  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, OUT, CMPL} state_t;

  state_t                           state_q, state_d;
  logic [OPCODE_W-1:0]              opcode_q;
  logic [BEAT_W-1:0]                beats_q;
  logic [BEAT_W-1:0]                beat_cnt_q;
  logic [TIMER_W-1:0]               timer_q;
  logic [SRC_CNT*OPERAND_WIDTH-1:0] operand_q;
  logic [OPERAND_WIDTH-1:0]         result_q;
  logic                             err_q;

  logic req_bad;
  logic is_last;
  logic timer_expired;

  logic req_ready, src_ready, lane_start, res_valid, res_last, cmpl_valid, cmpl_err;

  assign req_bad       = !LEGAL_OPC[bus.req_opcode_i] || (bus.req_beats_i == '0);
  assign is_last       = (beat_cnt_q == beats_q - BEAT_W'(1));
  assign timer_expired = (timer_q == TIMER_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and Moore handshake outputs
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    src_ready  = 1'b0;
    lane_start = 1'b0;
    res_valid  = 1'b0;
    res_last   = 1'b0;
    cmpl_valid = 1'b0;
    cmpl_err   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid_i) state_d = req_bad ? CMPL : FETCH;
      end
      FETCH: begin
        src_ready = 1'b1;
        if (bus.src_valid_i) state_d = ISSUE;
      end
      ISSUE: begin
        lane_start = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (bus.lane_done_i)  state_d = OUT;
        else if (timer_expired) state_d = CMPL;
      end
      OUT: begin
        res_valid = 1'b1;
        res_last  = is_last;
        if (bus.res_ready_i) state_d = is_last ? CMPL : FETCH;
      end
      CMPL: begin
        cmpl_valid = 1'b1;
        cmpl_err   = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Op context, beat counter, timeout timer and operand/result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q   <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      timer_q    <= '0;
      operand_q  <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid_i) begin
          opcode_q   <= bus.req_opcode_i;
          beats_q    <= bus.req_beats_i;
          beat_cnt_q <= '0;
          err_q      <= req_bad;
        end
        FETCH: if (bus.src_valid_i) operand_q <= bus.src_data_i;
        ISSUE: timer_q <= '0;
        WAIT: begin
          if (bus.lane_done_i) begin
            result_q <= bus.lane_dout_i;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
            if (timer_expired) err_q <= 1'b1;
          end
        end
        OUT: if (bus.res_ready_i && !is_last) beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o    = req_ready;
  assign bus.src_ready_o    = src_ready;
  assign bus.lane_start_o   = lane_start;
  assign bus.lane_opcode_o  = (state_q == IDLE) ? '0 : opcode_q;
  assign bus.lane_operand_o = operand_q;
  assign bus.res_valid_o    = res_valid;
  assign bus.res_data_o     = result_q;
  assign bus.res_last_o     = res_last;
  assign bus.cmpl_valid_o   = cmpl_valid;
  assign bus.cmpl_err_o     = cmpl_err;
  assign bus.busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_vpu_lane_seq_ctrl.sv
// Bench for vpu_lane_seq_ctrl: transaction-level expectation queues (operands
// per lane start, result beats, completions with latency) checked every cycle.
module tb_vpu_lane_seq_ctrl;
  localparam int OW = 32;
  localparam int SC = 3;
  localparam int OPW = 4;
  localparam int BW = 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vpu_lane_seq_ctrl_if #(.OPERAND_WIDTH(OW), .SRC_CNT(SC), .OPCODE_W(OPW), .BEAT_W(BW)) bus ();

  vpu_lane_seq_ctrl #(
    .OPERAND_WIDTH(OW), .SRC_CNT(SC), .OPCODE_W(OPW), .BEAT_W(BW),
    .TIMEOUT(TO), .LEGAL_OPC(16'h0FFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { logic [SC*OW-1:0] ops; logic [OPW-1:0] opc; } op_t;
  typedef struct { logic [OW-1:0] d; logic last; } res_t;
  typedef struct { logic err; int lat; } cmpl_t;

  op_t   op_q[$];
  res_t  res_q[$];
  cmpl_t cmpl_q[$];
  op_t   m_op;
  res_t  m_res;
  cmpl_t m_cmpl;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int acc_cyc, start_cyc, cmpl_cyc, last_res_cyc;
  int n_start = 0, n_src_rdy = 0, n_cmpl = 0, res_seen = 0;
  int lane_lat = 4;
  int stall_beat = -1, stall_left = 0;
  bit chk_period = 1'b0;
  bit spur_en = 1'b0;
  logic [OPW-1:0] cur_opc = '0;
  logic [OW-1:0]  last_res_data = '0;
  logic [OW-1:0]  r_val;

  logic          resp_done, spur_done;
  logic [OW-1:0] resp_dout;
  assign bus.lane_done_i = resp_done | spur_done;
  assign bus.lane_dout_i = resp_done ? resp_dout : 32'hDEAD_BEEF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: got event-missing expected event (cycle %0d)", name, cyc);
  endtask

  function automatic logic [SC*OW-1:0] gen_ops(input int seed, input int b);
    logic [SC*OW-1:0] r;
    for (int k = 0; k < SC; k++) r[k*OW +: OW] = 32'(seed * 256 + b * 16 + k);
    return r;
  endfunction

  // Behaviour of the emulated lane: sum of the three operands xor opcode
  function automatic logic [OW-1:0] lane_fn(input logic [SC*OW-1:0] ops, input logic [OPW-1:0] opc);
    return (ops[31:0] + ops[63:32] + ops[95:64]) ^ {28'd0, opc};
  endfunction

  // Compare process: every active cycle, outputs against expectation queues
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_vs_ready", bus.busy_o, !bus.req_ready_o);
      if (bus.req_ready_o) check("opcode_idle", bus.lane_opcode_o, 0);
      else                 check("opcode_held", bus.lane_opcode_o, cur_opc);
      if (bus.req_valid_i && bus.req_ready_o) acc_cyc = cyc;
      if (bus.src_ready_o) n_src_rdy++;
      if (bus.lane_start_o) begin
        n_start++;
        start_cyc = cyc;
        if (op_q.size() == 0) fail_now("unexpected_lane_start");
        else begin
          m_op = op_q.pop_front();
          check("lane_operand", bus.lane_operand_o, m_op.ops);
          check("lane_opcode", bus.lane_opcode_o, m_op.opc);
        end
      end
      if (bus.res_valid_o) begin
        if (res_q.size() == 0) fail_now("unexpected_res_beat");
        else begin
          m_res = res_q[0];
          check("res_data", bus.res_data_o, m_res.d);
          check("res_last", bus.res_last_o, m_res.last);
          if (bus.res_ready_i) begin
            if (chk_period && res_seen > 0) check("beat_period", cyc - last_res_cyc, 4);
            last_res_cyc  = cyc;
            last_res_data = bus.res_data_o;
            res_seen++;
            void'(res_q.pop_front());
          end
        end
      end
      if (bus.cmpl_valid_o) begin
        n_cmpl++;
        cmpl_cyc = cyc;
        if (cmpl_q.size() == 0) fail_now("unexpected_cmpl");
        else begin
          m_cmpl = cmpl_q.pop_front();
          check("cmpl_err", bus.cmpl_err_o, m_cmpl.err);
          if (m_cmpl.lat >= 0) check("req_to_cmpl", cyc - acc_cyc, m_cmpl.lat);
        end
      end
    end
  end

  // Emulated lane: done lane_lat cycles after start (never when lane_lat==0)
  initial begin
    resp_done = 1'b0;
    resp_dout = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.lane_start_o && lane_lat > 0) begin
        r_val = lane_fn(bus.lane_operand_o, bus.lane_opcode_o);
        @(posedge clk);
        repeat (lane_lat - 1) @(posedge clk);
        #1;
        resp_dout = r_val;
        resp_done = 1'b1;
        @(posedge clk);
        #1;
        resp_done = 1'b0;
      end
    end
  end

  // Result consumer: optional stall on one beat
  initial begin
    bus.res_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.res_valid_o && res_seen == stall_beat && stall_left > 0) begin
        bus.res_ready_i = 1'b0;
        stall_left--;
      end else bus.res_ready_i = 1'b1;
    end
  end

  // Spurious lane done in IDLE, FETCH and ISSUE cycles
  initial begin
    spur_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      spur_done = spur_en && (bus.req_ready_o || bus.src_ready_o || bus.lane_start_o);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic drive_req(input logic [OPW-1:0] opc, input logic [BW-1:0] beats);
    bus.req_opcode_i = opc;
    bus.req_beats_i  = beats;
    bus.req_valid_i  = 1'b1;
    for (int i = 0; i <= 1000; i++) begin
      if (i == 1000) begin fail_now("req_accept_timeout"); break; end
      @(negedge clk);
      if (bus.req_ready_o) break;
    end
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic drive_src(input int seed, input int n, input int gap);
    for (int b = 0; b < n; b++) begin
      if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
      bus.src_data_i  = gen_ops(seed, b);
      bus.src_valid_i = 1'b1;
      for (int i = 0; i <= 1000; i++) begin
        if (i == 1000) begin fail_now("src_accept_timeout"); bus.src_valid_i = 1'b0; return; end
        @(negedge clk);
        if (bus.src_ready_o) break;
      end
      @(posedge clk);
      #1;
      bus.src_valid_i = 1'b0;
    end
  endtask

  task automatic wait_cmpl(input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (n_cmpl >= target) return;
      @(negedge clk);
      #1;
    end
    fail_now("cmpl_timeout");
  endtask

  task automatic run_op(input logic [OPW-1:0] opc, input logic [BW-1:0] beats, input int seed,
                        input int n_src, input int gap, input bit push_res, input logic err,
                        input int lat);
    int tgt;
    tgt = n_cmpl + 1;
    cur_opc = opc;
    for (int b = 0; b < n_src; b++) op_q.push_back('{ops: gen_ops(seed, b), opc: opc});
    if (push_res)
      for (int b = 0; b < int'(beats); b++)
        res_q.push_back('{d: lane_fn(gen_ops(seed, b), opc), last: (b == int'(beats) - 1)});
    cmpl_q.push_back('{err: err, lat: lat});
    fork
      drive_req(opc, beats);
      drive_src(seed, n_src, gap);
    join
    wait_cmpl(tgt, 3000);
    check("op_q_drained", op_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    check("cmpl_q_drained", cmpl_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready_o, 1);
    check({tag, "_src_ready"}, bus.src_ready_o, 0);
    check({tag, "_lane_start"}, bus.lane_start_o, 0);
    check({tag, "_res_valid"}, bus.res_valid_o, 0);
    check({tag, "_res_last"}, bus.res_last_o, 0);
    check({tag, "_cmpl_valid"}, bus.cmpl_valid_o, 0);
    check({tag, "_cmpl_err"}, bus.cmpl_err_o, 0);
    check({tag, "_busy"}, bus.busy_o, 0);
    check({tag, "_lane_opcode"}, bus.lane_opcode_o, 0);
    check({tag, "_lane_operand"}, bus.lane_operand_o, 0);
    check({tag, "_res_data"}, bus.res_data_o, 0);
  endtask

  initial begin
    int n0;
    bus.req_valid_i  = 1'b0;
    bus.req_opcode_i = '0;
    bus.req_beats_i  = '0;
    bus.src_valid_i  = 1'b0;
    bus.src_data_i   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("in_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");
    @(posedge clk);
    #1;

    // 1) single beat, lane latency 4
    lane_lat = 4;
    n_start = 0; res_seen = 0;
    run_op(4'h1, 8'd1, 1, 1, 0, 1'b1, 1'b0, 8);
    check("t1_result_literal", last_res_data, 32'h302);
    check("t1_starts", n_start, 1);
    check("t1_beats", res_seen, 1);

    // 2) three beats, source gaps, stall on second beat
    lane_lat = 3;
    res_seen = 0; stall_beat = 1; stall_left = 3;
    run_op(4'h2, 8'd3, 2, 3, 2, 1'b1, 1'b0, -1);
    check("t2_beats", res_seen, 3);
    check("t2_stall_used", stall_left, 0);
    check("t2_last_literal", last_res_data, 32'h661);
    stall_beat = -1;

    // 3) illegal opcode, then zero beats
    n_start = 0; n_src_rdy = 0;
    run_op(4'hC, 8'd2, 3, 0, 0, 1'b0, 1'b1, 1);
    run_op(4'h3, 8'd0, 3, 0, 0, 1'b0, 1'b1, 1);
    check("t3_no_start", n_start, 0);
    check("t3_no_src_ready", n_src_rdy, 0);

    // 4) lane never answers
    lane_lat = 0;
    res_seen = 0;
    run_op(4'h5, 8'd3, 4, 1, 0, 1'b0, 1'b1, 11);
    check("t4_wait_cycles", cmpl_cyc - start_cyc - 1, TO);
    check("t4_no_res", res_seen, 0);
    check("t4_idle", bus.busy_o, 0);

    // 5a) spurious lane done in IDLE/FETCH/ISSUE
    lane_lat = 3;
    spur_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    res_seen = 0;
    run_op(4'h6, 8'd2, 5, 2, 3, 1'b1, 1'b0, -1);
    check("t5_beats", res_seen, 2);
    spur_en = 1'b0;

    // 5b) reset while waiting on the lane; stale done must be ignored
    lane_lat = 6;
    cur_opc = 4'h7;
    n0 = n_start;
    op_q.push_back('{ops: gen_ops(6, 0), opc: 4'h7});
    fork
      drive_req(4'h7, 8'd3);
      drive_src(6, 1, 0);
    join
    for (int i = 0; i <= 50; i++) begin
      if (n_start != n0) break;
      if (i == 50) fail_now("t5_start_timeout");
      @(negedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_op_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    n0 = n_cmpl;
    res_seen = 0;
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_cmpl_after_reset", n_cmpl, n0);
    check("t5_no_res_after_reset", res_seen, 0);
    check("t5_idle_after_reset", bus.req_ready_o, 1);
    lane_lat = 2;
    run_op(4'h8, 8'd2, 7, 2, 0, 1'b1, 1'b0, 11);
    check("t5_clean_beats", res_seen, 2);

    // 6) 255 beats back to back, lane latency 1
    lane_lat = 1;
    res_seen = 0;
    chk_period = 1'b1;
    run_op(4'h1, 8'd255, 9, 255, 0, 1'b1, 1'b0, 1021);
    chk_period = 1'b0;
    check("t6_beats", res_seen, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
